// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg
//   Shared constants for the bus_timer slave: register indices decoded from
//   addr[1:0], bit positions inside CTRL/INTR, and the bus read/write encoding.
package bus_timer_pkg;

  // Register indices (word address bits [1:0])
  localparam logic [1:0] TIMER_ADDR_CTRL    = 2'd0;
  localparam logic [1:0] TIMER_ADDR_INTR    = 2'd1;
  localparam logic [1:0] TIMER_ADDR_EXPR    = 2'd2;
  localparam logic [1:0] TIMER_ADDR_COUNTER = 2'd3;

  // Bit positions
  localparam int TIMER_START    = 0;  // CTRL
  localparam int TIMER_PERIODIC = 1;  // CTRL
  localparam int TIMER_FLAG     = 0;  // INTR

  // Bus direction encoding on rw
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

endpackage

// File: rtl/bus_timer.sv
// bus_timer
//   Memory-mapped interval timer on one slave port of the shared bus.
//   A free-running up-counter compares against EXPR; on a match it reloads 0,
//   sets the interrupt flag and, in one-shot mode, stops itself.
//   Every access (cs & as) is acknowledged with a registered one-cycle rdy
//   pulse in the following cycle; reads return the pre-edge register value.
//
// Ports
//   clk      in   system clock, rising edge
//   rest     in   asynchronous active-high reset
//   cs       in   chip select from the address decoder
//   as       in   address strobe; an access is cs & as
//   rw       in   1 = read, 0 = write
//   addr     in   word address [29:0]; only [1:0] decoded
//   wr_data  in   write data [31:0]
//   rd_data  out  read data [31:0], non-zero only while rdy = 1
//   rdy      out  one-cycle access acknowledge
//   irq      out  level interrupt, mirrors the INTR flag
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [31:0] RESET_EXPR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        cs,
  input  logic        as,
  input  logic        rw,
  input  logic [29:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy,
  output logic        irq
);

  logic        start_q,    start_d;
  logic        periodic_q, periodic_d;
  logic        flag_q,     flag_d;
  logic [31:0] expr_q,     expr_d;
  logic [31:0] counter_q,  counter_d;
  logic        rdy_q,      rdy_d;
  logic [31:0] rd_data_q,  rd_data_d;

  logic        access, wr_en, rd_en, expire;
  logic [1:0]  reg_sel;
  logic [31:0] reg_rd_val;

  // Upper address bits are deliberately ignored (register window aliases).
  logic unused_addr;
  assign unused_addr = ^addr[29:2];

  assign reg_sel = addr[1:0];
  assign access  = cs & as;
  assign wr_en   = access & (rw == WRITE);
  assign rd_en   = access & (rw == READ);
  assign expire  = start_q & (counter_q == expr_q);

  // Read mux over the current (pre-edge) register values.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    reg_rd_val = '0;
    unique case (reg_sel)
      TIMER_ADDR_CTRL:    reg_rd_val = {30'd0, periodic_q, start_q};
      TIMER_ADDR_INTR:    reg_rd_val = {31'd0, flag_q};
      TIMER_ADDR_EXPR:    reg_rd_val = expr_q;
      TIMER_ADDR_COUNTER: reg_rd_val = counter_q;
      default:            reg_rd_val = '0;
    endcase
  end

  // Next-state logic. Ordering of assignments encodes collision priority:
  // counter/control hardware updates first, then bus writes override them,
  // except the flag where an expiry set beats a software clear.
  always_comb begin
    start_d    = start_q;
    periodic_d = periodic_q;
    flag_d     = flag_q;
    expr_d     = expr_q;
    counter_d  = counter_q;

    if (start_q) begin
      counter_d = expire ? 32'd0 : counter_q + 32'd1;
    end
    if (expire && !periodic_q) begin
      start_d = 1'b0;
    end

    if (wr_en) begin
      unique case (reg_sel)
        TIMER_ADDR_CTRL: begin
          start_d    = wr_data[TIMER_START];
          periodic_d = wr_data[TIMER_PERIODIC];
        end
        TIMER_ADDR_INTR: begin
          if (wr_data[TIMER_FLAG]) flag_d = 1'b0;
        end
        TIMER_ADDR_EXPR:    expr_d    = wr_data;
        TIMER_ADDR_COUNTER: counter_d = wr_data;
        default: ;
      endcase
    end

    if (expire) begin
      flag_d = 1'b1;
    end

    rdy_d     = access;
    rd_data_d = rd_en ? reg_rd_val : 32'd0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      start_q    <= 1'b0;
      periodic_q <= 1'b0;
      flag_q     <= 1'b0;
      expr_q     <= RESET_EXPR;
      counter_q  <= 32'd0;
      rdy_q      <= 1'b0;
      rd_data_q  <= 32'd0;
    end else begin
      start_q    <= start_d;
      periodic_q <= periodic_d;
      flag_q     <= flag_d;
      expr_q     <= expr_d;
      counter_q  <= counter_d;
      rdy_q      <= rdy_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rdy     = rdy_q;
  assign rd_data = rd_data_q;
  assign irq     = flag_q;

endmodule
